// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a DEPTH-entry byte FIFO on the CPU peripheral bus.
// Configuration macro: UART_RX_IRQ_EN adds m_intr_o and a count threshold register at addr 2.
// Bus handshake: m_sel qualifies every access. m_wr is a one-cycle strobe that acts at the
// rising clk_i edge. Reads are combinational and have no side effects; only a write to
// addr 0 consumes a byte. There is no back-pressure: the bus never waits.
module uart_rx_fifo #(
    parameter int BAUDCNT    = 48,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m_sel,
    input  logic [3:0]  m_addr,
    input  logic [31:0] m_data_i,
    output logic [31:0] m_data_o,
    input  logic        m_rd,
    input  logic        m_wr,
    input  logic        RXD,
`ifdef UART_RX_IRQ_EN
    output logic        m_intr_o,
`endif
    output logic [1:0]  dbg_state
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [12:0] HALF_END = 13'(BAUDCNT / 2 - 1);
    localparam logic [12:0] BIT_END  = 13'(BAUDCNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [12:0]     tmr_q, tmr_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_meta, rxs;
    logic            rx_push, ferr_set;

    logic [7:0]      mem [DEPTH];
    logic [CW-1:0]   wr_ptr, rd_ptr, count;
    logic [7:0]      last_q, head_byte;
    logic            empty, full;
    logic            wr_sel, do_pop, do_push, ovf_set;
    logic            ovf_q, ferr_q, ovf_clr, ferr_clr;
    logic            unused_bits;

    assign unused_bits = ^{m_rd, m_data_i};
    assign dbg_state   = state_q;

    // Two-stage synchroniser for the asynchronous RXD pin; idles high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
        end
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
        end
    end

    // Receiver next state: half-bit start validation, then full-bit samples at mid-bit.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (tmr_q == HALF_END) begin
                    tmr_d    = '0;
                    bitcnt_d = '0;
                    state_d  = rxs ? S_IDLE : S_DATA;
                end else begin
                    tmr_d = tmr_q + 13'd1;
                end
            end
            S_DATA: begin
                if (tmr_q == BIT_END) begin
                    tmr_d    = '0;
                    shreg_d  = {rxs, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_STOP;
                end else begin
                    tmr_d = tmr_q + 13'd1;
                end
            end
            S_STOP: begin
                // Sampled mid stop bit, so a following start edge is caught at once.
                if (tmr_q == BIT_END) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                    if (rxs) rx_push  = 1'b1;
                    else     ferr_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + 13'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a pop frees the slot for a push in the same cycle.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = count[DEPTH_LOG2];
    assign wr_sel   = m_sel & m_wr;
    assign do_pop   = wr_sel & (m_addr == 4'd0) & ~empty;
    assign do_push  = rx_push & (~full | do_pop);
    assign ovf_set  = rx_push & full & ~do_pop;
    assign ovf_clr  = wr_sel & (m_addr == 4'd1) & m_data_i[3];
    assign ferr_clr = wr_sel & (m_addr == 4'd1) & m_data_i[2];

    // When empty the most recently consumed byte stays visible in the data register.
    assign head_byte = empty ? last_q : mem[rd_ptr[DEPTH_LOG2-1:0]];

    // FIFO storage; contents are don't-care until written, pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= shreg_q;
    end

    // Pointers, last-popped byte and sticky error flags (set beats clear).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            ovf_q  <= ovf_set  | (ovf_q  & ~ovf_clr);
            ferr_q <= ferr_set | (ferr_q & ~ferr_clr);
        end
    end

`ifdef UART_RX_IRQ_EN
    logic [CW-1:0] thr_q;

    // Threshold register and registered interrupt; threshold 0 masks the count term.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            thr_q    <= CW'(1);
            m_intr_o <= 1'b0;
        end else begin
            if (wr_sel && (m_addr == 4'd2)) thr_q <= m_data_i[DEPTH_LOG2:0];
            m_intr_o <= ((thr_q != '0) && (count >= thr_q)) || ovf_q || ferr_q;
        end
    end
`endif

    // Register read mux; zero whenever the peripheral is not selected.
    always_comb begin
        m_data_o = '0;
        if (m_sel) begin
            case (m_addr)
                4'd0: m_data_o = {23'b0, ~empty, head_byte};
                4'd1: m_data_o = {19'b0, 9'(count), ovf_q, ferr_q, full, empty};
`ifdef UART_RX_IRQ_EN
                4'd2: m_data_o = 32'(thr_q);
`endif
                default: m_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks for the buffered UART receiver with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BAUDCNT    = 48;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk_i    = 1'b0;
    logic        rst_i    = 1'b1;
    logic        m_sel    = 1'b0;
    logic [3:0]  m_addr   = 4'd0;
    logic [31:0] m_data_i = 32'd0;
    logic [31:0] m_data_o;
    logic        m_rd     = 1'b0;
    logic        m_wr     = 1'b0;
    logic        RXD      = 1'b1;
    logic [1:0]  dbg_state;
`ifdef UART_RX_IRQ_EN
    logic        m_intr_o;
`endif

    // clock / reset
    always #10 clk_i = ~clk_i;

    uart_rx_fifo #(.BAUDCNT(BAUDCNT), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m_sel    (m_sel),
        .m_addr   (m_addr),
        .m_data_i (m_data_i),
        .m_data_o (m_data_o),
        .m_rd     (m_rd),
        .m_wr     (m_wr),
        .RXD      (RXD),
`ifdef UART_RX_IRQ_EN
        .m_intr_o (m_intr_o),
`endif
        .dbg_state(dbg_state)
    );

    // scoreboard and reference flags
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_ferr = 1'b0;
    int         pass_cnt = 0;
    int         chk_cnt  = 0;

    function automatic logic [31:0] status_word(int cnt, bit ovf, bit ferr);
        logic [8:0] c9;
        c9 = 9'(cnt);
        return {19'b0, c9, ovf, ferr, (cnt == DEPTH), (cnt == 0)};
    endfunction

    // driver tasks
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        m_sel = 1'b1; m_wr = 1'b1; m_addr = a; m_data_i = d;
        @(negedge clk_i);
        m_sel = 1'b0; m_wr = 1'b0; m_data_i = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_i);
        m_sel = 1'b1; m_rd = 1'b1; m_addr = a;
        #1 d = m_data_o;
        m_sel = 1'b0; m_rd = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b, input bit stop_bit);
        @(negedge clk_i);
        RXD = 1'b0;
        repeat (BAUDCNT) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BAUDCNT) @(negedge clk_i);
        end
        RXD = stop_bit;
        repeat (BAUDCNT) @(negedge clk_i);
        RXD = 1'b1;
    endtask

    // Sends a frame and records what the receiver should have done with it.
    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        uart_send(b, stop_bit);
        if (!stop_bit)                 m_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                           m_ovf = 1'b1;
        repeat (BAUDCNT) @(negedge clk_i);
    endtask

    // Reads the head word, pops it, and returns observed and expected words.
    task automatic sb_pop(output logic [31:0] got, output logic [31:0] exp);
        bus_read(4'd0, got);
        if (exp_q.size() > 0) exp = {23'b0, 1'b1, exp_q[0]};
        else                  exp = {23'b0, 1'b0, m_last};
        bus_write(4'd0, 32'd0);
        if (exp_q.size() > 0) m_last = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] exp2;
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        chk_cnt++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state_in_reset: got %0d expected 0", dbg_state);
        else pass_cnt++;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        bus_read(4'd1, got);
        chk_cnt++;
        if (got !== 32'h1) $display("FAIL reset_status: got %h expected %h", got, 32'h1);
        else pass_cnt++;
        bus_read(4'd0, got);
        chk_cnt++;
        if (got !== 32'h0) $display("FAIL reset_data: got %h expected %h", got, 32'h0);
        else pass_cnt++;
`ifdef UART_RX_IRQ_EN
        exp2 = 32'h1;
`else
        exp2 = 32'h0;
`endif
        bus_read(4'd2, got);
        chk_cnt++;
        if (got !== exp2) $display("FAIL reset_addr2: got %h expected %h", got, exp2);
        else pass_cnt++;
        @(negedge clk_i);
        m_sel = 1'b0; m_addr = 4'd1;
        #1;
        chk_cnt++;
        if (m_data_o !== 32'h0) $display("FAIL unselected_read: got %h expected 0", m_data_o);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [31:0] got, exp;
        send_byte(8'hA5, 1'b1);
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL single_status: got %h expected %h", got, exp);
        else pass_cnt++;
        sb_pop(got, exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL single_data: got %h expected %h", got, exp);
        else pass_cnt++;
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL single_status_after_pop: got %h expected %h", got, exp);
        else pass_cnt++;
        bus_write(4'd0, 32'd0);
        bus_read(4'd0, got);
        exp = {23'b0, 1'b0, m_last};
        chk_cnt++;
        if (got !== exp) $display("FAIL pop_on_empty_data: got %h expected %h", got, exp);
        else pass_cnt++;
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL pop_on_empty_status: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1);
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL overflow_status: got %h expected %h", got, exp);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            sb_pop(got, exp);
            chk_cnt++;
            if (got !== exp) $display("FAIL overflow_pop%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
        bus_write(4'd1, 32'h8);
        m_ovf = 1'b0;
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL overflow_w1c: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_frame_err();
        logic [31:0] got, exp;
        send_byte(8'h3C, 1'b0);
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL ferr_status: got %h expected %h", got, exp);
        else pass_cnt++;
        send_byte(8'h55, 1'b1);
        sb_pop(got, exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL ferr_next_byte: got %h expected %h", got, exp);
        else pass_cnt++;
        bus_write(4'd1, 32'h4);
        m_ferr = 1'b0;
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL ferr_w1c: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [31:0] got, exp;
        @(negedge clk_i);
        RXD = 1'b0;
        repeat (5) @(negedge clk_i);
        chk_cnt++;
        if (dbg_state !== 2'd1) $display("FAIL glitch_start: got %0d expected 1", dbg_state);
        else pass_cnt++;
        repeat (5) @(negedge clk_i);
        RXD = 1'b1;
        repeat (BAUDCNT) @(negedge clk_i);
        chk_cnt++;
        if (dbg_state !== 2'd0) $display("FAIL glitch_idle: got %0d expected 0", dbg_state);
        else pass_cnt++;
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL glitch_status: got %h expected %h", got, exp);
        else pass_cnt++;
    endtask

    // Full FIFO, pop lands exactly in the stop-sample cycle of the next byte.
    task automatic test_back_to_back();
        logic [31:0] got, exp;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i), 1'b1);
        fork
            uart_send(8'h77, 1'b1);
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 12 * BAUDCNT && !seen; n++) begin
                    @(negedge clk_i);
                    if (dbg_state == 2'd3) seen = 1'b1;
                end
                chk_cnt++;
                if (!seen) $display("FAIL b2b_stop_timeout: got no STOP state expected STOP");
                else begin
                    pass_cnt++;
                    repeat (BAUDCNT - 2) @(negedge clk_i);
                    bus_write(4'd0, 32'd0);
                    m_last = exp_q.pop_front();
                end
            end
        join
        exp_q.push_back(8'h77);
        repeat (BAUDCNT) @(negedge clk_i);
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL b2b_status: got %h expected %h", got, exp);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            sb_pop(got, exp);
            chk_cnt++;
            if (got !== exp) $display("FAIL b2b_pop%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got, exp;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        @(negedge clk_i);
        RXD = 1'b0;
        repeat (5 * BAUDCNT) @(negedge clk_i);
        RXD = 1'b1;
        repeat (BAUDCNT / 2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_ferr = 1'b0; m_last = 8'h00;
        repeat (4 * BAUDCNT) @(negedge clk_i);
        bus_read(4'd1, got);
        exp = status_word(exp_q.size(), m_ovf, m_ferr);
        chk_cnt++;
        if (got !== exp) $display("FAIL rstmid_status: got %h expected %h", got, exp);
        else pass_cnt++;
`ifdef UART_RX_IRQ_EN
        bus_write(4'd2, 32'd2);
`endif
        send_byte(8'hC3, 1'b1);
`ifdef UART_RX_IRQ_EN
        chk_cnt++;
        if (m_intr_o !== 1'b0) $display("FAIL irq_below_thr: got %b expected 0", m_intr_o);
        else pass_cnt++;
`endif
        send_byte(8'h96, 1'b1);
`ifdef UART_RX_IRQ_EN
        chk_cnt++;
        if (m_intr_o !== 1'b1) $display("FAIL irq_at_thr: got %b expected 1", m_intr_o);
        else pass_cnt++;
`endif
        for (int i = 0; i < 2; i++) begin
            sb_pop(got, exp);
            chk_cnt++;
            if (got !== exp) $display("FAIL rstmid_pop%0d: got %h expected %h", i, got, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
